sparse_dense_cyc_mul: RTL and testbench

Parametrised sparse-by-dense cyclic multiplier controller over GF(2)[x]/(x^R − 1) for the BIKE key-generation datapath. It computes f ← f ⊕ g·h, or f ← g·h when cleared first, where h is a list of WT sparse indices and g, f are dense W-bit-word memories. It is the generalised successor of the fixed r = 11027, 64-bit multiplier:
- any R, W and WT;
- runtime choice of h or its transpose (x^{−h_i});
- clear-or-accumulate mode;
- a fixed, predictable per-word schedule.

---
 rtl/sparse_dense_cyc_mul_if.sv | 33 +++
 rtl/sparse_dense_cyc_mul.sv | 241 ++++++++++++++++++++++++
 tb/tb_sparse_dense_cyc_mul.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sparse_dense_cyc_mul_if.sv
// Memory/handshake bundle for the sparse-by-dense cyclic multiplier.
// master: the multiplier controller. slave: host plus the h/g/f memories.
interface sparse_dense_cyc_mul_if #(
  parameter int W        = 64,
  parameter int G_ADDR_W = 8,
  parameter int H_ADDR_W = 7,
  parameter int H_DAT_W  = 14
);
  logic                start;
  logic                clr;
  logic                transpose;
  logic                busy;
  logic                done;
  logic                err;
  logic [H_ADDR_W-1:0] h_addr;
  logic [H_DAT_W-1:0]  h_rd_data;
  logic [G_ADDR_W-1:0] g_addr;
  logic [W-1:0]        g_rd_data;
  logic [G_ADDR_W-1:0] f_addr;
  logic [W-1:0]        f_rd_data;
  logic                f_we;
  logic [W-1:0]        f_wr_data;

  modport master (
    input  start, clr, transpose, h_rd_data, g_rd_data, f_rd_data,
    output busy, done, err, h_addr, g_addr, f_addr, f_we, f_wr_data
  );

  modport slave (
    output start, clr, transpose, h_rd_data, g_rd_data, f_rd_data,
    input  busy, done, err, h_addr, g_addr, f_addr, f_we, f_wr_data
  );
endinterface

// File: rtl/sparse_dense_cyc_mul.sv
// Sparse-by-dense cyclic multiplier over GF(2)[x]/(x^R - 1).
// f <- f ^ g*h (or f <- g*h with clr), h a list of WT sparse exponents,
// optionally transposed (x^-h_i). Fixed 4-cycle schedule per output word.
// Optional: define SDMUL_INDEX_CHECK_EN to flag and skip indices h >= R.
module sparse_dense_cyc_mul #(
  parameter int R        = 11027,
  parameter int W        = 64,
  parameter int WT       = 67,
  parameter int L        = (R + W - 1) / W,
  parameter int G_ADDR_W = 8,
  parameter int H_ADDR_W = 7,
  parameter int H_DAT_W  = 14
) (
  input logic clk,
  input logic rst,
  sparse_dense_cyc_mul_if.master bus
);
  localparam int LW = $clog2(W);
  localparam int V  = R - (L - 1) * W;        // valid bits in last word
  localparam int SW = H_DAT_W + 1;            // s + W must not overflow
  localparam int IW = $clog2(WT + 1);
  localparam int TW = G_ADDR_W + 2;
  localparam logic [W-1:0]        VMASK  = {W{1'b1}} >> (W - V);
  localparam logic [G_ADDR_W-1:0] LAST_A = G_ADDR_W'(L - 1);
  localparam logic [IW-1:0]       LAST_I = IW'(WT - 1);

  typedef enum logic [2:0] {IDLE, IDX0, IDX1, P0, P1, P2, P3} state_t;

  // (a + d) mod L for d < L, computed wide so G_ADDR_W = clog2(L) is safe
  function automatic logic [G_ADDR_W-1:0] wrap_add(input logic [G_ADDR_W-1:0] a,
                                                   input int unsigned d);
    logic [TW-1:0] t;
    t = TW'(a) + TW'(d);
    if (t >= TW'(L)) t = t - TW'(L);
    return t[G_ADDR_W-1:0];
  endfunction

  function automatic logic [W-1:0] word_mask(input logic [G_ADDR_W-1:0] a);
    return (a == LAST_A) ? VMASK : {W{1'b1}};
  endfunction

  state_t              state_q, state_n;
  logic [IW-1:0]       i_q, i_n;
  logic [G_ADDR_W-1:0] j_q, j_n;
  logic [SW-1:0]       s_q, s_n, s_step, h_ext;
  logic                clr_q, clr_n, tr_q, tr_n;
  logic [W-1:0]        wa_q, wa_n, wb_q, wb_n, f_old_q, f_old_n;
  logic                busy_q, busy_n, done_q, done_n, f_we_q, f_we_n;
  logic [H_ADDR_W-1:0] h_addr_q, h_addr_n;
  logic [G_ADDR_W-1:0] g_addr_q, g_addr_n, f_addr_q, f_addr_n, a_n;
  logic                last_word, last_idx;
`ifdef SDMUL_INDEX_CHECK_EN
  logic                err_q, err_n;
`endif

  // state, counters, captured words and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      s_q      <= '0;
      clr_q    <= 1'b0;
      tr_q     <= 1'b0;
      wa_q     <= '0;
      wb_q     <= '0;
      f_old_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      f_we_q   <= 1'b0;
      h_addr_q <= '0;
      g_addr_q <= '0;
      f_addr_q <= '0;
`ifdef SDMUL_INDEX_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_n;
      i_q      <= i_n;
      j_q      <= j_n;
      s_q      <= s_n;
      clr_q    <= clr_n;
      tr_q     <= tr_n;
      wa_q     <= wa_n;
      wb_q     <= wb_n;
      f_old_q  <= f_old_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      f_we_q   <= f_we_n;
      h_addr_q <= h_addr_n;
      g_addr_q <= g_addr_n;
      f_addr_q <= f_addr_n;
`ifdef SDMUL_INDEX_CHECK_EN
      err_q    <= err_n;
`endif
    end
  end

  // next state and next values of the registered outputs
  always_comb begin
    state_n   = state_q;
    i_n       = i_q;
    j_n       = j_q;
    s_n       = s_q;
    clr_n     = clr_q;
    tr_n      = tr_q;
    wa_n      = wa_q;
    wb_n      = wb_q;
    f_old_n   = f_old_q;
    done_n    = 1'b0;
`ifdef SDMUL_INDEX_CHECK_EN
    err_n     = err_q;
`endif
    last_word = (j_q == LAST_A);
    last_idx  = (i_q == LAST_I);
    h_ext     = SW'(bus.h_rd_data);
    s_step    = s_q + SW'(W);
    if (s_step >= SW'(R)) s_step = s_step - SW'(R);

    case (state_q)
      IDLE: if (bus.start) begin
        state_n = IDX0;
        i_n     = '0;
        clr_n   = bus.clr;
        tr_n    = bus.transpose;
`ifdef SDMUL_INDEX_CHECK_EN
        err_n   = 1'b0;
`endif
      end
      IDX0: state_n = IDX1;
      IDX1: begin
        // window start s = (R - k) mod R; for the transpose this is just h
        if (tr_q)              s_n = h_ext;
        else if (h_ext == '0)  s_n = '0;
        else                   s_n = SW'(R) - h_ext;
        j_n     = '0;
        state_n = P0;
`ifdef SDMUL_INDEX_CHECK_EN
        if (h_ext >= SW'(R)) begin
          err_n = 1'b1;
          i_n   = i_q + IW'(1);
          if (last_idx) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = IDX0;
          end
        end
`endif
      end
      P0: state_n = P1;
      P1: begin
        wa_n    = bus.g_rd_data;
        f_old_n = bus.f_rd_data;
        state_n = P2;
      end
      P2: begin
        wb_n    = bus.g_rd_data;
        state_n = P3;
      end
      P3: begin
        s_n = s_step;
        j_n = j_q + G_ADDR_W'(1);
        if (last_word) begin
          i_n = i_q + IW'(1);
          if (last_idx) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = IDX0;
          end
        end else begin
          state_n = P0;
        end
      end
      default: state_n = IDLE;
    endcase

    // outputs follow the state being entered so they are valid in that state
    busy_n   = (state_n != IDLE);
    h_addr_n = '0;
    g_addr_n = '0;
    f_addr_n = '0;
    f_we_n   = 1'b0;
    a_n      = G_ADDR_W'(s_n >> LW);
    case (state_n)
      IDX0: h_addr_n = H_ADDR_W'(i_n);
      P0: begin
        g_addr_n = a_n;
        f_addr_n = j_n;
      end
      P1: begin
        g_addr_n = wrap_add(a_n, 1);
        f_addr_n = j_n;
      end
      P2: begin
        g_addr_n = wrap_add(a_n, 2);
        f_addr_n = j_n;
      end
      P3: begin
        f_we_n   = 1'b1;
        f_addr_n = j_n;
      end
      default: ;
    endcase
  end

  logic [G_ADDR_W-1:0] a_idx, b_idx, c_idx;
  logic [W-1:0]        win, wr_word;
  int                  off, la, lb, na;

  // window assembly: A from bit s%W, then B, then C; third word is used
  // straight off the read port since it only arrives in P3
  always_comb begin
    a_idx   = G_ADDR_W'(s_q >> LW);
    b_idx   = wrap_add(a_idx, 1);
    c_idx   = wrap_add(a_idx, 2);
    off     = int'(s_q[LW-1:0]);
    la      = (a_idx == LAST_A) ? V : W;
    lb      = (b_idx == LAST_A) ? V : W;
    na      = la - off;
    win     = ((wa_q & word_mask(a_idx)) >> off)
            | ((wb_q & word_mask(b_idx)) << na)
            | ((bus.g_rd_data & word_mask(c_idx)) << (na + lb));
    wr_word = ((clr_q && i_q == '0) ? '0 : f_old_q) ^ win;
    if (j_q == LAST_A) wr_word = wr_word & VMASK;
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.h_addr    = h_addr_q;
  assign bus.g_addr    = g_addr_q;
  assign bus.f_addr    = f_addr_q;
  assign bus.f_we      = f_we_q;
  assign bus.f_wr_data = (state_q == P3) ? wr_word : '0;
`ifdef SDMUL_INDEX_CHECK_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_sparse_dense_cyc_mul.sv
// Bench for sparse_dense_cyc_mul: small ring (R=131, W=8, L=17, V=3) with
// behavioural memories and a bit-level cyclic-product reference model.
module tb_sparse_dense_cyc_mul;
  localparam int R = 131, W = 8, WT = 3, L = (R + W - 1) / W;
  localparam int G_ADDR_W = 5, H_ADDR_W = 2, H_DAT_W = 8;
  localparam int N_CYC = WT * (2 + 4 * L);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0, failures = 0, cyc = 0;

  sparse_dense_cyc_mul_if #(.W(W), .G_ADDR_W(G_ADDR_W), .H_ADDR_W(H_ADDR_W),
                            .H_DAT_W(H_DAT_W)) bus();
  sparse_dense_cyc_mul #(.R(R), .W(W), .WT(WT), .L(L), .G_ADDR_W(G_ADDR_W),
                         .H_ADDR_W(H_ADDR_W), .H_DAT_W(H_DAT_W))
    dut (.clk(clk), .rst(rst), .bus(bus));

  logic [W-1:0]       g_mem[L], f_mem[L], f_init[L], f_base[L], exp_f[L];
  logic [H_DAT_W-1:0] h_mem[WT];
  bit                 load_f = 1'b0;
  int                 we_log[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 1-cycle-latency memories
  always @(posedge clk) begin
    bus.h_rd_data <= (int'(bus.h_addr) < WT) ? h_mem[bus.h_addr] : '0;
    bus.g_rd_data <= (int'(bus.g_addr) < L) ? g_mem[bus.g_addr] : '0;
    bus.f_rd_data <= (int'(bus.f_addr) < L) ? f_mem[bus.f_addr] : '0;
    if (load_f) for (int w = 0; w < L; w++) f_mem[w] <= f_init[w];
    else if (bus.f_we && int'(bus.f_addr) < L) f_mem[bus.f_addr] <= bus.f_wr_data;
  end

  always @(negedge clk) if (bus.f_we) we_log.push_back(cyc);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // f = base ^ sum_i g * x^k_i, with base = 0 under clr
  task automatic model(input bit c, input bit t);
    bit gb[R];
    bit fb[R];
    int k, h;
    for (int m = 0; m < R; m++) begin
      gb[m] = g_mem[m / W][m % W];
      fb[m] = c ? 1'b0 : f_base[m / W][m % W];
    end
    for (int i = 0; i < WT; i++) begin
      h = int'(h_mem[i]);
`ifdef SDMUL_INDEX_CHECK_EN
      if (h >= R) continue;
`endif
      k = t ? ((h == 0) ? 0 : R - h) : h;
      for (int m = 0; m < R; m++) fb[(m + k) % R] ^= gb[m];
    end
    for (int w = 0; w < L; w++) exp_f[w] = '0;
    for (int m = 0; m < R; m++) exp_f[m / W][m % W] = fb[m];
  endtask

  task automatic load_f_mem();
    for (int w = 0; w < L; w++) f_base[w] = f_init[w];
    @(negedge clk); load_f = 1'b1;
    @(negedge clk); load_f = 1'b0;
  endtask

  task automatic rand_g();
    for (int w = 0; w < L; w++) g_mem[w] = W'($urandom);
    g_mem[L-1] = g_mem[L-1] & 8'h07;
  endtask

  task automatic rand_f();
    for (int w = 0; w < L; w++) f_init[w] = W'($urandom);
    f_init[L-1] = f_init[L-1] & 8'h07;
  endtask

  task automatic run_op(input bit c, input bit t, input string nm);
    int e, nskip;
    nskip = 0;
`ifdef SDMUL_INDEX_CHECK_EN
    for (int i = 0; i < WT; i++) if (int'(h_mem[i]) >= R) nskip++;
`endif
    model(c, t);
    we_log.delete();
    @(negedge clk);
    bus.start = 1'b1; bus.clr = c; bus.transpose = t;
    @(negedge clk);
    e = cyc;
    bus.start = 1'b0; bus.clr = 1'($urandom); bus.transpose = 1'($urandom);
    chk($sformatf("%s_busy_rise", nm), 64'(bus.busy), 64'(1));
    while (!bus.done && (cyc - e) < 4 * N_CYC) begin
      @(negedge clk);
      bus.start = ((cyc - e) == 20);   // stray start while busy
    end
    bus.start = 1'b0;
    chk($sformatf("%s_done_seen", nm), 64'(bus.done), 64'(1));
    chk($sformatf("%s_latency", nm), 64'(cyc - e), 64'(N_CYC - nskip * 4 * L));
    chk($sformatf("%s_busy_at_done", nm), 64'(bus.busy), 64'(0));
    chk($sformatf("%s_err", nm), 64'(bus.err), 64'(nskip > 0));
    chk($sformatf("%s_we_count", nm), 64'(we_log.size()), 64'((WT - nskip) * L));
    if (nskip == 0 && we_log.size() > 0) begin
      chk($sformatf("%s_first_we", nm), 64'(we_log[0] - e), 64'(5));
      chk($sformatf("%s_last_we", nm), 64'(we_log[we_log.size()-1] - e), 64'(N_CYC - 1));
    end
    @(negedge clk);
    chk($sformatf("%s_done_pulse", nm), 64'(bus.done), 64'(0));
    for (int w = 0; w < L; w++)
      chk($sformatf("%s_f[%0d]", nm, w), 64'(f_mem[w]), 64'(exp_f[w]));
  endtask

  initial begin
    bus.start = 1'b0; bus.clr = 1'b0; bus.transpose = 1'b0;
    for (int w = 0; w < L; w++) begin g_mem[w] = '0; f_init[w] = '0; end
    for (int i = 0; i < WT; i++) h_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_err", 64'(bus.err), 64'(0));
    chk("rst_f_we", 64'(bus.f_we), 64'(0));
    chk("rst_h_addr", 64'(bus.h_addr), 64'(0));
    chk("rst_g_addr", 64'(bus.g_addr), 64'(0));
    chk("rst_f_addr", 64'(bus.f_addr), 64'(0));
    chk("rst_f_wr_data", 64'(bus.f_wr_data), 64'(0));
    rst = 1'b0;

    // g = 1, h = {5,0,0}: x^5 + 1 + 1 = x^5
    g_mem[0] = 8'h01;
    h_mem[0] = 8'd5; h_mem[1] = 8'd0; h_mem[2] = 8'd0;
    rand_f(); load_f_mem();
    run_op(1'b1, 1'b0, "x5");
    chk("x5_word0_const", 64'(f_mem[0]), 64'h20);
    // transpose: x^(R-5) = x^126 -> word 15 bit 6
    rand_f(); load_f_mem();
    run_op(1'b1, 1'b1, "x5t");
    chk("x5t_word15_const", 64'(f_mem[15]), 64'h40);
    chk("x5t_word16_const", 64'(f_mem[16]), 64'h00);

    // boundary straddle indices
    h_mem[0] = 8'd130; h_mem[1] = 8'd0; h_mem[2] = 8'd64;
    rand_g(); rand_f(); load_f_mem();
    run_op(1'b1, 1'b0, "straddle");
    rand_f(); load_f_mem();
    run_op(1'b1, 1'b1, "straddle_t");

    // random patterns
    for (int n = 0; n < 6; n++) begin
      rand_g(); rand_f();
      for (int i = 0; i < WT; i++) h_mem[i] = H_DAT_W'($urandom_range(R - 1, 0));
      load_f_mem();
      run_op(1'($urandom), 1'($urandom), $sformatf("rnd%0d", n));
    end

    // accumulate twice with the same h -> f back to where it started
    rand_g(); rand_f();
    for (int i = 0; i < WT; i++) h_mem[i] = H_DAT_W'($urandom_range(R - 1, 0));
    load_f_mem();
    run_op(1'b0, 1'b0, "acc1");
    for (int w = 0; w < L; w++) f_base[w] = exp_f[w];
    run_op(1'b0, 1'b0, "acc2");
    for (int w = 0; w < L; w++)
      chk($sformatf("acc_restore[%0d]", w), 64'(f_mem[w]), 64'(f_init[w]));

    // reset mid-operation
    @(negedge clk);
    bus.start = 1'b1; bus.clr = 1'b1; bus.transpose = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(bus.busy), 64'(0));
    chk("midrst_f_we", 64'(bus.f_we), 64'(0));
    chk("midrst_done", 64'(bus.done), 64'(0));
    @(negedge clk);
    chk("midrst_f_we2", 64'(bus.f_we), 64'(0));
    rst = 1'b0;
    rand_f(); load_f_mem();
    run_op(1'b1, 1'b0, "after_rst");

`ifdef SDMUL_INDEX_CHECK_EN
    h_mem[0] = 8'd200; h_mem[1] = 8'd3; h_mem[2] = 8'd7;
    rand_g(); rand_f(); load_f_mem();
    run_op(1'b1, 1'b0, "badidx");
    h_mem[0] = 8'd9;
    rand_f(); load_f_mem();
    run_op(1'b1, 1'b0, "err_clear");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
